// File: rtl/serial_word_compare.sv
// serial_word_compare: accumulates per-bit XNOR match results over a framed
// serial word and reports word completion, equality and mismatch count.
module serial_word_compare #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           DigitSupply,
  input  logic                 MatchBit,
  input  logic                 BitValid,
  input  logic                 FrameStart,
  output logic                 WordDone,
  output logic                 WordEqual,
  output logic [CNT_WIDTH-1:0] MismatchCount,
  output logic [CNT_WIDTH-1:0] BitIndex,
  output logic                 Abort
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORD_WIDTH);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 equal_q, equal_d;
  logic                 abort_q, abort_d;

  logic                 clear;
  logic                 start;
  logic                 step_bit;
  logic [CNT_WIDTH-1:0] miss;

  // Power-fail behaves exactly like reset; a start bit is only meaningful with BitValid.
  assign clear    = reset || (DigitSupply != 2'b10);
  assign start    = BitValid && FrameStart;
  assign step_bit = BitValid && !FrameStart;
  assign miss     = MatchBit ? '0 : ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a one-bit word completes on its start bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (ONE == LAST_IDX) ? DONE : COMPARE;
      end
      COMPARE: begin
        if (start) begin
          state_d = COMPARE;
        end else if (step_bit && ((idx_q + ONE) == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = (ONE == LAST_IDX) ? DONE : COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; WordDone and WordEqual are set on entry to DONE.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    equal_d = equal_q;
    abort_d = 1'b0;
    if (start) begin
      idx_d   = ONE;
      cnt_d   = miss;
      abort_d = (state_q == COMPARE);
    end else if (step_bit && (state_q == COMPARE)) begin
      idx_d = idx_q + ONE;
      cnt_d = cnt_q + miss;
    end
    if (state_d == DONE) begin
      done_d  = 1'b1;
      equal_d = (cnt_d == '0);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      abort_q <= abort_d;
    end
  end

  assign WordDone      = done_q;
  assign WordEqual     = equal_q;
  assign MismatchCount = cnt_q;
  assign BitIndex      = idx_q;
  assign Abort         = abort_q;

endmodule
